// File: rtl/mdio_pkg.sv
// MDIO Clause 22 shared definitions: frame constants, FSM state encoding, frame-word builder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int MDIO_PRE_BITS   = 32;
  localparam int MDIO_FRAME_BITS = 64;
  // Frame bit positions (bit counter values) where TA and DATA begin.
  localparam int MDIO_TA_BIT     = 46;
  localparam int MDIO_DATA_BIT   = 48;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} mdio_state_e;

  // Everything after the preamble, MSB first. Reads carry zeros in TA/DATA;
  // those bits are never driven because mdoEn is low there.
  function automatic logic [31:0] mdio_word(input logic        write,
                                            input logic [4:0]  phy,
                                            input logic [4:0]  regad,
                                            input logic [15:0] wdata);
    if (write)
      return {MDIO_ST, MDIO_OP_WR, phy, regad, MDIO_TA_WR, wdata};
    else
      return {MDIO_ST, MDIO_OP_RD, phy, regad, 2'b00, 16'h0000};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// MDIO master request/response bus plus MDIO pad signals.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; rsp_valid is a pulse with no ready.
// Ports: req_* request fields, rsp_* completion, mdc/mdo/mdoEn/mdi pad side.
interface mdio_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        no_preamble;
  logic [4:0]  req_phy;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        mdc;
  logic        mdo;
  logic        mdoEn;
  logic        mdi;

  // master: the MDIO master block itself.
  modport master (
    input  req_valid, req_write, no_preamble, req_phy, req_reg, req_wdata, mdi,
    output req_ready, rsp_valid, rsp_rdata, mdc, mdo, mdoEn
  );

  // slave: the register file / pad side that talks to the master.
  modport slave (
    output req_valid, req_write, no_preamble, req_phy, req_reg, req_wdata, mdi,
    input  req_ready, rsp_valid, rsp_rdata, mdc, mdo, mdoEn
  );
endinterface

// File: rtl/mdio_clkgen.sv
// MDC generator: CLK_DIV cycles low then CLK_DIV cycles high per bit, strobes at bit end.
// Latency: first low phase starts the cycle i_en rises; mdc is forced low whenever i_en is low.
// Backpressure: none; free-running while enabled.
// Ports: clock/reset, i_en (frame active), o_mdc, o_fall_stb (this edge drops mdc and
//        starts the next bit), o_samp_stb (last high cycle of the bit: sample mdi now).
module mdio_clkgen #(
  parameter int CLK_DIV = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_mdc,
  output logic o_fall_stb,
  output logic o_samp_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_mdc;
  logic       w_wrap;

  assign w_wrap = (r_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      // Holding the counter at zero makes the first bit start cleanly on enable.
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_mdc      = r_mdc;
  // The last high cycle is both the sampling point and the edge where the next bit begins.
  assign o_samp_stb = i_en && r_mdc && w_wrap;
  assign o_fall_stb = o_samp_stb;

endmodule

// File: rtl/mdio_master.sv
// MDIO Clause 22 master: serialises one read/write request into a 64 (or 32) bit frame.
// Latency: rsp_valid pulses N*2*CLK_DIV+1 cycles after the accept edge (N = 64, or 32 without preamble).
// Backpressure: req_ready only in IDLE; a held request waits and is accepted the cycle after rsp_valid.
// Ports: clock, reset (async, active-high), bus (mdio_master_if.master: request, response, MDIO pad).
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 20
) (
  input  logic          clock,
  input  logic          reset,
  mdio_master_if.master bus
);

  mdio_state_e r_state;
  logic [5:0]  r_bitcnt;
  logic [31:0] r_shift;
  logic        r_write;
  logic        r_mdo;
  logic        r_mdoen;
  logic        r_rsp_vld;
  logic [15:0] r_rdata;
  logic        r_mdi_s1;
  logic        r_mdi_s2;

  logic        w_active;
  logic        w_accept;
  logic        w_mdc;
  logic        w_fall_stb;
  logic        w_samp_stb;
  logic [5:0]  w_next_bit;
  logic        w_next_mdo;
  logic        w_next_en;

  assign w_active   = (r_state == PRE) || (r_state == HDR) || (r_state == TA) || (r_state == DATA);
  assign w_accept   = bus.req_valid && (r_state == IDLE);
  assign w_next_bit = r_bitcnt + 6'd1;

  // Preamble bits are constant ones. On the first post-preamble bit the shift
  // register has not moved yet, so its MSB is the bit; afterwards the shift
  // happens on the same edge and the following bit sits at [30].
  assign w_next_mdo = (w_next_bit < 6'(MDIO_PRE_BITS)) ? 1'b1 :
                      (r_bitcnt   < 6'(MDIO_PRE_BITS)) ? r_shift[31] : r_shift[30];
  // Reads release the line from the turnaround onwards.
  assign w_next_en  = r_write || (w_next_bit < 6'(MDIO_TA_BIT));

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clock      (clock),
    .reset      (reset),
    .i_en       (w_active),
    .o_mdc      (w_mdc),
    .o_fall_stb (w_fall_stb),
    .o_samp_stb (w_samp_stb)
  );

  // mdi comes from the pad, unrelated to clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mdi_s1 <= 1'b0;
      r_mdi_s2 <= 1'b0;
    end else begin
      r_mdi_s1 <= bus.mdi;
      r_mdi_s2 <= r_mdi_s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_write   <= 1'b0;
      r_mdo     <= 1'b0;
      r_mdoen   <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_vld <= 1'b0;
          if (w_accept) begin
            r_write <= bus.req_write;
            r_shift <= mdio_word(bus.req_write, bus.req_phy, bus.req_reg, bus.req_wdata);
            r_rdata <= '0;
            r_mdoen <= 1'b1;
            if (bus.no_preamble) begin
              r_state  <= HDR;
              r_bitcnt <= 6'(MDIO_PRE_BITS);
              r_mdo    <= MDIO_ST[1];
            end else begin
              r_state  <= PRE;
              r_bitcnt <= '0;
              r_mdo    <= 1'b1;
            end
          end
        end

        PRE, HDR, TA, DATA: begin
          if (w_samp_stb && (r_state == DATA) && !r_write)
            r_rdata <= {r_rdata[14:0], r_mdi_s2};
          if (w_fall_stb) begin
            if (r_bitcnt == 6'(MDIO_FRAME_BITS - 1)) begin
              r_state   <= DONE;
              r_rsp_vld <= 1'b1;
              r_mdo     <= 1'b0;
              r_mdoen   <= 1'b0;
            end else begin
              r_bitcnt <= w_next_bit;
              if (w_next_bit == 6'(MDIO_PRE_BITS))
                r_state <= HDR;
              else if (w_next_bit == 6'(MDIO_TA_BIT))
                r_state <= TA;
              else if (w_next_bit == 6'(MDIO_DATA_BIT))
                r_state <= DATA;
              if (r_bitcnt >= 6'(MDIO_PRE_BITS))
                r_shift <= {r_shift[30:0], 1'b0};
              r_mdoen <= w_next_en;
              r_mdo   <= w_next_en & w_next_mdo;
            end
          end
        end

        DONE: begin
          r_rsp_vld <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_rdata = r_rdata;
  assign bus.mdc       = w_mdc;
  assign bus.mdo       = r_mdo;
  assign bus.mdoEn     = r_mdoen;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: table of directed frames at CLK_DIV=4, then back-to-back,
// mid-frame reset and CLK_DIV=255 sequences. PHY models present each read bit
// correctly only in one cycle of the high phase, so sampling time is checked.
module tb_mdio_master;

  localparam int D0 = 4;
  localparam int D1 = 255;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mdio_master_if b0();
  mdio_master_if b1();

  mdio_master #(.CLK_DIV(D0)) u_dut0 (.clock(clock), .reset(reset), .bus(b0.master));
  mdio_master #(.CLK_DIV(D1)) u_dut1 (.clock(clock), .reset(reset), .bus(b1.master));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- PHY models ----------------
  // fcnt = frame bit currently on the wire (mdc falls since accept),
  // hcnt = index of the current cycle within the mdc-high phase.
  function automatic logic phy_bit(input int f, input int h, input int n,
                                   input logic [15:0] d, input int div);
    logic b;
    if (f >= n - 16 && f < n) begin
      b = d[n - 1 - f];
      return (h == div - 3) ? b : ~b;
    end
    return 1'b1;
  endfunction

  logic [15:0] phy_data0 = '0, phy_data1 = '0;
  int phy_n0 = 64, phy_n1 = 32;
  int fcnt0 = 0, hcnt0 = 0, fcnt1 = 0, hcnt1 = 0;
  logic mdc_q0 = 1'b0, mdc_q1 = 1'b0;

  always @(posedge clock) begin
    if (b0.req_valid && b0.req_ready) fcnt0 <= 0;
    else if (mdc_q0 && !b0.mdc)       fcnt0 <= fcnt0 + 1;
    mdc_q0 <= b0.mdc;
    hcnt0  <= b0.mdc ? hcnt0 + 1 : 0;
  end

  always @(posedge clock) begin
    if (b1.req_valid && b1.req_ready) fcnt1 <= 0;
    else if (mdc_q1 && !b1.mdc)       fcnt1 <= fcnt1 + 1;
    mdc_q1 <= b1.mdc;
    hcnt1  <= b1.mdc ? hcnt1 + 1 : 0;
  end

  assign b0.mdi = phy_bit(fcnt0, hcnt0, phy_n0, phy_data0, D0);
  assign b1.mdi = phy_bit(fcnt1, hcnt1, phy_n1, phy_data1, D1);

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        write;
    logic        nopre;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] phy_data;
    logic [63:0] exp_mdo;
    logic [63:0] exp_en;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v);
    logic [63:0] cap_mdo, cap_en;
    logic [15:0] rsp_dat;
    logic        cur_mdo, cur_en, rsp_mdc;
    int nbits, per, ph, rsp_k, rsp_cnt, shape_err, stab_err;
    bit accepted;
    nbits = v.nopre ? 32 : 64;
    per   = 2 * D0;
    phy_n0 = nbits;
    phy_data0 = v.phy_data;
    @(negedge clock);
    b0.req_write = v.write; b0.no_preamble = v.nopre; b0.req_phy = v.phy;
    b0.req_reg = v.regad; b0.req_wdata = v.wdata; b0.req_valid = 1'b1;
    accepted = 0;
    for (int w = 0; w < 2000 && !accepted; w++) begin
      if (b0.req_ready === 1'b1) accepted = 1;
      else @(negedge clock);
    end
    check({v.name, "_accept"}, accepted, 1);
    if (!accepted) begin
      b0.req_valid = 1'b0;
      return;
    end
    cap_mdo = '0; cap_en = '0; rsp_dat = '0; rsp_mdc = 1'bx;
    cur_mdo = 1'b0; cur_en = 1'b0;
    rsp_k = -1; rsp_cnt = 0; shape_err = 0; stab_err = 0;
    for (int k = 1; k <= nbits * per + 3; k++) begin
      @(negedge clock);
      if (k == 1) b0.req_valid = 1'b0;
      if (k <= nbits * per) begin
        ph = (k - 1) % per;
        if (b0.mdc !== (ph >= D0)) shape_err++;
        if (b0.req_ready !== 1'b0) shape_err++;
        if (ph == 0) begin
          cur_mdo = b0.mdo;
          cur_en  = b0.mdoEn;
          cap_mdo = {cap_mdo[62:0], cur_mdo};
          cap_en  = {cap_en[62:0], cur_en};
        end else if (b0.mdo !== cur_mdo || b0.mdoEn !== cur_en) begin
          stab_err++;
        end
        if (b0.mdoEn === 1'b0 && b0.mdo !== 1'b0) stab_err++;
      end
      if (b0.rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_k < 0) begin
          rsp_k   = k;
          rsp_dat = b0.rsp_rdata;
          rsp_mdc = b0.mdc;
        end
      end
    end
    check({v.name, "_mdc_shape"}, shape_err, 0);
    check({v.name, "_bit_stable"}, stab_err, 0);
    check({v.name, "_mdo_seq"}, cap_mdo, v.exp_mdo);
    check({v.name, "_mdoen_seq"}, cap_en, v.exp_en);
    check({v.name, "_rsp_cycle"}, rsp_k, v.exp_lat);
    check({v.name, "_rsp_width"}, rsp_cnt, 1);
    check({v.name, "_rdata"}, rsp_dat, v.exp_rdata);
    check({v.name, "_mdc_at_rsp"}, rsp_mdc, 1'b0);
  endtask

  initial begin
    int acc_n, rsp_n, cnt, cnt2, rsp_k;
    int acc_c[2], rsp_c[2];
    logic [15:0] rsp_d[2];
    logic [1:0]  gap_mdc;
    int hi_min, hi_max, lo_min, lo_max, run, hi_runs;
    logic lvl;
    logic [15:0] rdat;

    vecs[0] = '{"wr_pre",     1'b1, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000,
                64'hFFFFFFFF_50821140, 64'hFFFFFFFF_FFFFFFFF, 513, 16'h0000};
    vecs[1] = '{"rd_pre",     1'b0, 1'b0, 5'h1F, 5'h02, 16'hDEAD, 16'h7949,
                64'hFFFFFFFF_6F880000, 64'hFFFFFFFF_FFFC0000, 513, 16'h7949};
    vecs[2] = '{"rd_nopre",   1'b0, 1'b1, 5'h05, 5'h1B, 16'h0000, 16'hA5C3,
                64'h00000000_62EC0000, 64'h00000000_FFFC0000, 257, 16'hA5C3};
    vecs[3] = '{"wr_nopre",   1'b1, 1'b1, 5'h1F, 5'h1F, 16'hBEEF, 16'h0000,
                64'h00000000_5FFEBEEF, 64'h00000000_FFFFFFFF, 257, 16'h0000};
    vecs[4] = '{"rd_nopre_0", 1'b0, 1'b1, 5'h00, 5'h00, 16'h0000, 16'h8001,
                64'h00000000_60000000, 64'h00000000_FFFC0000, 257, 16'h8001};

    reset = 1'b1;
    b0.req_valid = 0; b0.req_write = 0; b0.no_preamble = 0;
    b0.req_phy = '0; b0.req_reg = '0; b0.req_wdata = '0;
    b1.req_valid = 0; b1.req_write = 0; b1.no_preamble = 0;
    b1.req_phy = '0; b1.req_reg = '0; b1.req_wdata = '0;
    repeat (3) @(negedge clock);
    check("reset_ready", b0.req_ready, 1'b1);
    check("reset_rsp_valid", b0.rsp_valid, 1'b0);
    check("reset_rdata", b0.rsp_rdata, 16'h0000);
    check("reset_mdc", b0.mdc, 1'b0);
    check("reset_mdo", b0.mdo, 1'b0);
    check("reset_mdoen", b0.mdoEn, 1'b0);
    check("reset_div255_pins", {b1.req_ready, b1.mdc, b1.mdoEn}, 3'b100);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // ---- back-to-back with req_valid held ----
    @(negedge clock);
    phy_n0 = 32; phy_data0 = 16'h5A5A;
    b0.req_write = 1; b0.no_preamble = 1; b0.req_phy = 5'h02; b0.req_reg = 5'h03;
    b0.req_wdata = 16'h0F0F; b0.req_valid = 1;
    acc_n = 0; rsp_n = 0; gap_mdc = 2'b11;
    acc_c[0] = -1; acc_c[1] = -1; rsp_c[0] = -1; rsp_c[1] = -1;
    rsp_d[0] = 'x; rsp_d[1] = 'x;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clock);
      if (b0.rsp_valid === 1'b1) begin
        if (rsp_n < 2) begin rsp_c[rsp_n] = c; rsp_d[rsp_n] = b0.rsp_rdata; end
        rsp_n++;
      end
      if (rsp_n >= 1 && c == rsp_c[0]) gap_mdc[1] = b0.mdc;
      if (rsp_n >= 1 && c == rsp_c[0] + 1) gap_mdc[0] = b0.mdc;
      if (b0.req_valid === 1'b1 && b0.req_ready === 1'b1) begin
        if (acc_n < 2) acc_c[acc_n] = c;
        acc_n++;
      end else if (acc_n == 2 && b0.req_valid === 1'b1) begin
        b0.req_valid = 0;
      end
      if (c == 1) begin
        b0.req_write = 0; b0.req_phy = 5'h04; b0.req_reg = 5'h05; b0.req_wdata = 16'h0000;
      end
    end
    b0.req_valid = 0;
    check("b2b_accepts", acc_n, 2);
    check("b2b_rsp_count", rsp_n, 2);
    check("b2b_first_rsp", rsp_c[0], 257);
    check("b2b_second_accept", acc_c[1], rsp_c[0] + 1);
    check("b2b_mdc_gap", gap_mdc, 2'b00);
    check("b2b_second_rsp", rsp_c[1], acc_c[1] + 257);
    check("b2b_wr_rdata", rsp_d[0], 16'h0000);
    check("b2b_rd_rdata", rsp_d[1], 16'h5A5A);

    // ---- reset during DATA of a write ----
    repeat (3) @(negedge clock);
    b0.req_write = 1; b0.no_preamble = 0; b0.req_phy = 5'h00; b0.req_reg = 5'h00;
    b0.req_wdata = 16'hFFFF; b0.req_valid = 1;
    @(negedge clock);
    b0.req_valid = 0;
    repeat (399) @(negedge clock);
    check("rst_mid_frame_pins", {b0.mdc, b0.mdoEn, b0.mdo, b0.req_ready}, 4'b1110);
    reset = 1'b1;
    @(negedge clock);
    check("rst_outputs", {b0.mdc, b0.mdoEn, b0.mdo, b0.req_ready, b0.rsp_valid}, 5'b00010);
    check("rst_rdata", b0.rsp_rdata, 16'h0000);
    reset = 1'b0;
    cnt = 0; cnt2 = 0;
    repeat (600) begin
      @(negedge clock);
      if (b0.rsp_valid !== 1'b0) cnt++;
      if (b0.mdc !== 1'b0) cnt2++;
    end
    check("rst_no_rsp", cnt, 0);
    check("rst_mdc_quiet", cnt2, 0);

    // ---- CLK_DIV=255 read without preamble ----
    phy_n1 = 32; phy_data1 = 16'h36C9;
    @(negedge clock);
    b1.req_write = 0; b1.no_preamble = 1; b1.req_phy = 5'h03; b1.req_reg = 5'h04;
    b1.req_wdata = 16'h0000; b1.req_valid = 1;
    check("div255_ready", b1.req_ready, 1'b1);
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0; hi_runs = 0;
    run = 0; lvl = 1'b0; rsp_k = -1; rdat = 'x;
    for (int c = 1; c <= 32 * 2 * D1 + 3; c++) begin
      @(negedge clock);
      if (c == 1) b1.req_valid = 0;
      if (b1.mdc === lvl) begin
        run++;
      end else begin
        if (c > 1) begin
          if (lvl) begin
            hi_runs++;
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end else begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
        end
        lvl = b1.mdc;
        run = 1;
      end
      if (b1.rsp_valid === 1'b1 && rsp_k < 0) begin
        rsp_k = c;
        rdat = b1.rsp_rdata;
      end
    end
    check("div255_hi_runs", hi_runs, 32);
    check("div255_hi_min", hi_min, 255);
    check("div255_hi_max", hi_max, 255);
    check("div255_lo_min", lo_min, 255);
    check("div255_lo_max", lo_max, 255);
    check("div255_rsp_cycle", rsp_k, 16321);
    check("div255_rdata", rdat, 16'h36C9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
